// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync code, LSB-first payload, optional even parity, idle gap.
// Optional parity bit is compiled in with `define SYNC_FRAME_TX_PARITY_EN.
module sync_frame_tx #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [3:0]  SYNC_CODE  = 4'b1001,
  parameter int          GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  data_out,
  output logic                  data_out_en,
  output logic                  frame_done
);

  localparam int MAX_A   = (DATA_WIDTH > 4) ? DATA_WIDTH : 4;
  localparam int MAX_LEN = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  // Valid/ready: a word transfers on a rising edge where tx_valid && tx_ready are both high;
  // tx_data is captured at that edge only, and tx_valid is ignored while tx_ready is low.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    ready_q, ready_d;
  logic                    dout_q, dout_d;
  logic                    en_q, en_d;
  logic                    done_q, done_d;
  logic                    enter_tail;
  logic [1:0]              sync_idx;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic                    par_q, par_d;
`endif

  assign sync_idx = cnt_q[1:0] + 2'd1;

  // Outputs are the registered value of the bit for the phase held in state_q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ready_d    = ready_q;
    dout_d     = 1'b0;
    en_d       = 1'b0;
    done_d     = 1'b0;
    enter_tail = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
          shift_d = tx_data;
          ready_d = 1'b0;
          dout_d  = SYNC_CODE[0];
          en_d    = 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      ST_SYNC: begin
        en_d = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          dout_d  = shift_q[0];
          shift_d = shift_q >> 1;
          done_d  = (DATA_WIDTH == 1) && !PAR_EN;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          dout_d = SYNC_CODE[sync_idx];
        end
      end
      ST_PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
          state_d = ST_PARITY;
          cnt_d   = '0;
          dout_d  = par_q;
          en_d    = 1'b1;
          done_d  = 1'b1;
`else
          enter_tail = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          dout_d  = shift_q[0];
          shift_d = shift_q >> 1;
          en_d    = 1'b1;
          done_d  = (cnt_d == PAY_LAST) && !PAR_EN;
        end
      end
`ifdef SYNC_FRAME_TX_PARITY_EN
      ST_PARITY: begin
        enter_tail = 1'b1;
      end
`endif
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
      end
    endcase

    // Last frame bit has been shown; go to the gap, or straight to idle when there is none.
    if (enter_tail) begin
      cnt_d = '0;
      if (GAP_CYCLES == 0) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end else begin
        state_d = ST_GAP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      done_q  <= done_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign data_out    = dout_q;
  assign data_out_en = en_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: default-gap instance (a) and zero-gap instance (b),
// expected frame bits queued at the handshake and compared as they appear.
module tb_sync_frame_tx;

  localparam int DW    = 8;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;
`ifdef SYNC_FRAME_TX_PARITY_EN
  localparam int FL = 13;
`else
  localparam int FL = 12;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_d, a_en, a_fd;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready, b_d, b_en, b_fd;
  logic [DW-1:0] b_data;

  sync_frame_tx #(.DATA_WIDTH(DW), .SYNC_CODE(4'b1001), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(a_valid), .tx_data(a_data),
    .tx_ready(a_ready), .data_out(a_d), .data_out_en(a_en), .frame_done(a_fd)
  );

  sync_frame_tx #(.DATA_WIDTH(DW), .SYNC_CODE(4'b1001), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(b_valid), .tx_data(b_data),
    .tx_ready(b_ready), .data_out(b_d), .data_out_en(b_en), .frame_done(b_fd)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_a_q[$];
  logic [1:0] exp_b_q[$];
  logic [1:0] e_a, e_b;
  logic [3:0] det_hist = 4'b0000;
  int det_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected entries are {frame_done, data_out}; frame_done only on the final bit.
  task automatic push_frame(input logic [DW-1:0] d, input bit to_b);
    logic [3:0] sc;
    logic [1:0] item;
    int k;
    sc = 4'b1001;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      item = {(k == FL - 1), sc[i]};
      if (to_b) exp_b_q.push_back(item); else exp_a_q.push_back(item);
      k++;
    end
    for (int i = 0; i < DW; i++) begin
      item = {(k == FL - 1), d[i]};
      if (to_b) exp_b_q.push_back(item); else exp_a_q.push_back(item);
      k++;
    end
`ifdef SYNC_FRAME_TX_PARITY_EN
    item = {1'b1, ^d};
    if (to_b) exp_b_q.push_back(item); else exp_a_q.push_back(item);
`endif
  endtask

  always @(negedge clk) begin
    if (a_en) begin
      if (exp_a_q.size() == 0) check_eq("a_unexpected_bit", exp_a_q.size(), 1);
      else begin
        e_a = exp_a_q.pop_front();
        check_eq("a_bit", {a_fd, a_d}, e_a);
      end
    end else check_eq("a_idle_out", {a_fd, a_d}, 2'b00);
    if (b_en) begin
      if (exp_b_q.size() == 0) check_eq("b_unexpected_bit", exp_b_q.size(), 1);
      else begin
        e_b = exp_b_q.pop_front();
        check_eq("b_bit", {b_fd, b_d}, e_b);
      end
    end else check_eq("b_idle_out", {b_fd, b_d}, 2'b00);
    det_hist <= {det_hist[2:0], a_d};
    if ({det_hist[2:0], a_d} == 4'b1001) det_count <= det_count + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [DW-1:0] d);
    int guard;
    guard = 0;
    while (!a_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("a_ready_wait_timeout", (guard < 200), 1);
    a_valid = 1'b1;
    a_data  = d;
    push_frame(d, 1'b0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data  = DW'($urandom);
    check_eq("a_ready_drop", a_ready, 0);
    check_eq("a_first_bit", {a_en, a_d}, 2'b11);
  endtask

  task automatic wait_ready_a(output int n);
    n = 0;
    while (!a_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_ready_b(output int n);
    n = 0;
    while (!b_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int d0;
    logic [DW-1:0] rd;
    a_valid = 1'b1;
    a_data  = DW'($urandom);
    b_valid = 1'b1;
    b_data  = DW'($urandom);
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_ready", a_ready, 1);
    check_eq("rst_a_out", {a_en, a_fd, a_d}, 3'b000);
    check_eq("rst_b_ready", b_ready, 1);
    check_eq("rst_b_out", {b_en, b_fd, b_d}, 3'b000);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;

    // basic frame
    send_a(8'hA5);
    wait_ready_a(n);
    check_eq("a5_ready_latency", n, FL + GAP_A);

    // parity words
    send_a(8'h01);
    wait_ready_a(n);
    check_eq("p01_ready_latency", n, FL + GAP_A);
    send_a(8'h03);
    wait_ready_a(n);
    check_eq("p03_ready_latency", n, FL + GAP_A);

    // back-to-back on the zero-gap instance
    b_valid = 1'b1;
    b_data  = 8'hFF;
    push_frame(8'hFF, 1'b1);
    @(posedge clk); #1;
    b_data = 8'h00;
    push_frame(8'h00, 1'b1);
    check_eq("b_ready_drop", b_ready, 0);
    wait_ready_b(n);
    check_eq("b_ready_latency", n, FL);
    check_eq("b_idle_between", {b_en, b_d}, 2'b00);
    @(posedge clk); #1;
    check_eq("b_second_sync", {b_en, b_d, b_ready}, 3'b110);
    b_valid = 1'b0;
    wait_ready_b(n);
    check_eq("b_second_latency", n, FL);

    // busy: data change and valid pulse mid-frame
    send_a(8'h3C);
    repeat (5) @(posedge clk);
    #1;
    a_data  = 8'hC3;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_ready_a(n);
    check_eq("busy_ready_latency", n + 6, FL + GAP_A);
    repeat (FL + 4) @(posedge clk);
    #1;
    check_eq("busy_no_extra_frame", a_ready, 1);

    // reset during payload bit 3
    send_a(8'h5A);
    repeat (7) @(posedge clk);
    #2;
    check_eq("pre_reset_bit3", {a_en, a_d}, 2'b11);
    a_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_eq("midrst_ready", a_ready, 1);
    check_eq("midrst_out", {a_en, a_fd, a_d}, 3'b000);
    exp_a_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_hold_out", {a_en, a_fd, a_d, a_ready}, 4'b0001);
    a_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    send_a(8'h96);
    wait_ready_a(n);
    check_eq("post_rst_latency", n, FL + GAP_A);

    // loopback detection: one sync hit per all-zero frame
    d0 = det_count;
    for (int i = 0; i < 3; i++) begin
      send_a(8'h00);
      wait_ready_a(n);
    end
    check_eq("loopback_detect", det_count - d0, 3);

    // random words
    for (int i = 0; i < 6; i++) begin
      rd = DW'($urandom_range(0, 255));
      send_a(rd);
      wait_ready_a(n);
      check_eq("rand_ready_latency", n, FL + GAP_A);
    end

    repeat (5) @(posedge clk);
    #1;
    check_eq("a_queue_empty", exp_a_q.size(), 0);
    check_eq("b_queue_empty", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
